// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the Ethernet test-frame generator.
package eth_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        GAP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        MODE_INC   = 2'd0,
        MODE_CONST = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_SEQ   = 2'd3
    } tx_mode_e;

    localparam int          HDR_WORDS = 8;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps for x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/eth_payload_lfsr.sv
// 16-bit payload LFSR; steps once per cycle with advance high.
module eth_payload_lfsr
    import eth_tx_pkg::*;
(
    input  logic        CLOCK_25,
    input  logic        Reset,
    input  logic        advance,
    output logic [15:0] lfsr_state
);

    logic [15:0] lfsr_r;

    // LFSR state register with synchronous reload of the seed.
    always_ff @(posedge CLOCK_25) begin
        if (Reset) begin
            lfsr_r <= LFSR_SEED;
        end else if (advance) begin
            lfsr_r <= lfsr_step(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign lfsr_state = lfsr_r;

endmodule

// File: rtl/eth_tx_frame_gen.sv
// Ethernet test-frame generator driving the EthernetTop send interface:
// header + sequence word + patterned payload, burst or continuous runs.
module eth_tx_frame_gen
    import eth_tx_pkg::*;
#(
    parameter int          DATA_W         = 16,
    parameter int          CNT_W          = 16,
    parameter int          MIN_PAYLOAD    = 22,
    parameter int          MAX_PAYLOAD    = 742,
    parameter logic [47:0] DST_MAC        = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC        = 48'h0001_0203_0405,
    parameter logic [15:0] ETHERTYPE      = 16'h88B5,
    parameter int          GAP_CYCLES     = 1000,
    parameter int          TIMEOUT_CYCLES = 65535
) (
    input  logic              CLOCK_25,
    input  logic              Reset,
    input  logic              start_tx,
    input  logic              stop_tx,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  payload_words,
    input  logic [CNT_W-1:0]  frame_count,
    input  logic [DATA_W-1:0] const_word,
    input  logic              tx_packet_data_rdy_in,
    input  logic              tx_complete_in,
    output logic              tx_req_out,
    output logic [DATA_W-1:0] tx_packet_data_out,
    output logic              busy,
    output logic [CNT_W-1:0]  frames_sent,
    output logic              error_out,
    output logic [8:0]        Debug_LEDG
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    tx_state_e         state_r,  state_nx_s;
    tx_mode_e          mode_r,   mode_nx_s;
    logic [CNT_W-1:0]  idx_r,    idx_nx_s;
    logic [CNT_W-1:0]  len_r,    len_nx_s;
    logic [CNT_W-1:0]  fcount_r, fcount_nx_s;
    logic [CNT_W-1:0]  sent_r,   sent_nx_s;
    logic [DATA_W-1:0] const_r,  const_nx_s;
    logic [DATA_W-1:0] data_r,   data_nx_s;
    logic [15:0]       seq_r,    seq_nx_s;
    logic [GAP_W-1:0]  gap_r,    gap_nx_s;
    logic [WD_W-1:0]   wd_r,     wd_nx_s;
    logic              stop_pend_r, stop_nx_s;
    logic              req_r,    req_nx_s;
    logic              busy_r,   busy_nx_s;
    logic              err_r,    err_nx_s;

    logic [15:0]       lfsr_q_s;
    logic [15:0]       lfsr_pick_s;
    logic              lfsr_adv_s;
    logic [CNT_W-1:0]  nidx_s;
    logic [CNT_W-1:0]  pidx_s;
    logic [DATA_W-1:0] payload_s;
    logic [DATA_W-1:0] next_word_s;
    logic              last_frame_s;
    logic [1:0]        state_bits_s;

    // Total frame length in words with the payload clamped to the legal range.
    function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] pw);
        if (pw < CNT_W'(MIN_PAYLOAD)) begin
            return CNT_W'(MIN_PAYLOAD + HDR_WORDS);
        end else if (pw > CNT_W'(MAX_PAYLOAD)) begin
            return CNT_W'(MAX_PAYLOAD + HDR_WORDS);
        end else begin
            return pw + CNT_W'(HDR_WORDS);
        end
    endfunction

    eth_payload_lfsr u_lfsr (
        .CLOCK_25   (CLOCK_25),
        .Reset      (Reset),
        .advance    (lfsr_adv_s),
        .lfsr_state (lfsr_q_s)
    );

    assign last_frame_s = (fcount_r != {CNT_W{1'b0}}) && ((sent_r + CNT_W'(1)) == fcount_r);

    // Word to present after the current one is consumed.
    always_comb begin
        nidx_s = idx_r + CNT_W'(1);
        pidx_s = nidx_s - CNT_W'(HDR_WORDS);
        // Consuming an LFSR payload word steps the register this edge, so look one step further.
        if ((mode_r == MODE_LFSR) && (idx_r >= CNT_W'(HDR_WORDS))) begin
            lfsr_pick_s = lfsr_step(lfsr_step(lfsr_q_s));
        end else begin
            lfsr_pick_s = lfsr_step(lfsr_q_s);
        end
        case (mode_r)
            MODE_INC:   payload_s = DATA_W'(pidx_s);
            MODE_CONST: payload_s = const_r;
            MODE_LFSR:  payload_s = DATA_W'(lfsr_pick_s);
            MODE_SEQ:   payload_s = DATA_W'(seq_r);
            default:    payload_s = {DATA_W{1'b0}};
        endcase
        if (nidx_s >= len_r) begin
            next_word_s = {DATA_W{1'b0}};
        end else begin
            case (nidx_s)
                CNT_W'(0): next_word_s = DST_MAC[47:32];
                CNT_W'(1): next_word_s = DST_MAC[31:16];
                CNT_W'(2): next_word_s = DST_MAC[15:0];
                CNT_W'(3): next_word_s = SRC_MAC[47:32];
                CNT_W'(4): next_word_s = SRC_MAC[31:16];
                CNT_W'(5): next_word_s = SRC_MAC[15:0];
                CNT_W'(6): next_word_s = ETHERTYPE;
                CNT_W'(7): next_word_s = DATA_W'(seq_r);
                default:   next_word_s = payload_s;
            endcase
        end
    end

    // Next-state and next-output logic of the frame FSM.
    always_comb begin
        state_nx_s  = state_r;
        mode_nx_s   = mode_r;
        idx_nx_s    = idx_r;
        len_nx_s    = len_r;
        fcount_nx_s = fcount_r;
        sent_nx_s   = sent_r;
        const_nx_s  = const_r;
        data_nx_s   = data_r;
        seq_nx_s    = seq_r;
        gap_nx_s    = gap_r;
        wd_nx_s     = wd_r;
        stop_nx_s   = stop_pend_r;
        req_nx_s    = req_r;
        busy_nx_s   = busy_r;
        err_nx_s    = err_r;
        lfsr_adv_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_tx) begin
                    state_nx_s  = REQ;
                    mode_nx_s   = tx_mode_e'(mode);
                    const_nx_s  = const_word;
                    fcount_nx_s = frame_count;
                    len_nx_s    = clamp_len(payload_words);
                    seq_nx_s    = 16'h0000;
                    sent_nx_s   = {CNT_W{1'b0}};
                    err_nx_s    = 1'b0;
                    busy_nx_s   = 1'b1;
                    req_nx_s    = 1'b1;
                    stop_nx_s   = stop_tx;
                    idx_nx_s    = {CNT_W{1'b0}};
                    wd_nx_s     = {WD_W{1'b0}};
                    data_nx_s   = DST_MAC[47:32];
                end else begin
                    stop_nx_s = 1'b0;
                    busy_nx_s = 1'b0;
                    req_nx_s  = 1'b0;
                end
            end
            REQ, WAIT: begin
                wd_nx_s = wd_r + WD_W'(1);
                if (stop_tx) begin
                    stop_nx_s = 1'b1;
                end else begin
                    stop_nx_s = stop_pend_r;
                end
                if ((state_r == REQ) && tx_packet_data_rdy_in) begin
                    idx_nx_s   = nidx_s;
                    data_nx_s  = next_word_s;
                    lfsr_adv_s = (mode_r == MODE_LFSR) && (idx_r >= CNT_W'(HDR_WORDS));
                    if (idx_r == (len_r - CNT_W'(1))) begin
                        state_nx_s = WAIT;
                    end else begin
                        state_nx_s = REQ;
                    end
                end else begin
                    lfsr_adv_s = 1'b0;
                end
                // Completion wins over the watchdog and may arrive before the last word.
                if (tx_complete_in) begin
                    req_nx_s  = 1'b0;
                    data_nx_s = {DATA_W{1'b0}};
                    idx_nx_s  = {CNT_W{1'b0}};
                    sent_nx_s = sent_r + CNT_W'(1);
                    seq_nx_s  = seq_r + 16'd1;
                    if (last_frame_s || stop_pend_r || stop_tx) begin
                        state_nx_s = IDLE;
                        busy_nx_s  = 1'b0;
                        stop_nx_s  = 1'b0;
                    end else begin
                        state_nx_s = GAP;
                        gap_nx_s   = {GAP_W{1'b0}};
                    end
                end else if (wd_r == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nx_s = IDLE;
                    req_nx_s   = 1'b0;
                    data_nx_s  = {DATA_W{1'b0}};
                    idx_nx_s   = {CNT_W{1'b0}};
                    busy_nx_s  = 1'b0;
                    stop_nx_s  = 1'b0;
                    err_nx_s   = 1'b1;
                end else begin
                    err_nx_s = err_r;
                end
            end
            GAP: begin
                if (stop_tx) begin
                    state_nx_s = IDLE;
                    busy_nx_s  = 1'b0;
                    stop_nx_s  = 1'b0;
                end else if (gap_r == GAP_W'(GAP_CYCLES - 1)) begin
                    state_nx_s = REQ;
                    req_nx_s   = 1'b1;
                    wd_nx_s    = {WD_W{1'b0}};
                    idx_nx_s   = {CNT_W{1'b0}};
                    data_nx_s  = DST_MAC[47:32];
                end else begin
                    gap_nx_s = gap_r + GAP_W'(1);
                end
            end
            default: begin
                state_nx_s = IDLE;
                req_nx_s   = 1'b0;
                busy_nx_s  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLOCK_25) begin
        if (Reset) begin
            state_r     <= IDLE;
            mode_r      <= MODE_INC;
            idx_r       <= {CNT_W{1'b0}};
            len_r       <= {CNT_W{1'b0}};
            fcount_r    <= {CNT_W{1'b0}};
            sent_r      <= {CNT_W{1'b0}};
            const_r     <= {DATA_W{1'b0}};
            data_r      <= {DATA_W{1'b0}};
            seq_r       <= 16'h0000;
            gap_r       <= {GAP_W{1'b0}};
            wd_r        <= {WD_W{1'b0}};
            stop_pend_r <= 1'b0;
            req_r       <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            mode_r      <= mode_nx_s;
            idx_r       <= idx_nx_s;
            len_r       <= len_nx_s;
            fcount_r    <= fcount_nx_s;
            sent_r      <= sent_nx_s;
            const_r     <= const_nx_s;
            data_r      <= data_nx_s;
            seq_r       <= seq_nx_s;
            gap_r       <= gap_nx_s;
            wd_r        <= wd_nx_s;
            stop_pend_r <= stop_nx_s;
            req_r       <= req_nx_s;
            busy_r      <= busy_nx_s;
            err_r       <= err_nx_s;
        end
    end

    assign state_bits_s       = state_r;
    assign tx_req_out         = req_r;
    assign tx_packet_data_out = data_r;
    assign busy               = busy_r;
    assign frames_sent        = sent_r;
    assign error_out          = err_r;
    assign Debug_LEDG         = {err_r, busy_r, req_r, state_bits_s, sent_r[3:0]};

endmodule

// File: tb/tb_eth_tx_frame_gen.sv
// Directed self-checking bench for eth_tx_frame_gen.
module tb_eth_tx_frame_gen;

    logic        CLOCK_25 = 1'b0;
    logic        Reset = 1'b1;
    logic        start_tx = 1'b0;
    logic        stop_tx = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] payload_words = 16'd0;
    logic [15:0] frame_count = 16'd0;
    logic [15:0] const_word = 16'd0;
    logic        tx_packet_data_rdy_in = 1'b0;
    logic        tx_complete_in = 1'b0;
    logic        tx_req_out;
    logic [15:0] tx_packet_data_out;
    logic        busy;
    logic [15:0] frames_sent;
    logic        error_out;
    logic [8:0]  Debug_LEDG;

    int          n_tests = 0;
    int          n_fail = 0;
    int          hold_errs = 0;
    logic [15:0] got_w [0:63];
    logic [15:0] exp_w [0:63];
    logic [15:0] lfsr_m = 16'hACE1;

    eth_tx_frame_gen #(.TIMEOUT_CYCLES(200)) dut (
        .CLOCK_25              (CLOCK_25),
        .Reset                 (Reset),
        .start_tx              (start_tx),
        .stop_tx               (stop_tx),
        .mode                  (mode),
        .payload_words         (payload_words),
        .frame_count           (frame_count),
        .const_word            (const_word),
        .tx_packet_data_rdy_in (tx_packet_data_rdy_in),
        .tx_complete_in        (tx_complete_in),
        .tx_req_out            (tx_req_out),
        .tx_packet_data_out    (tx_packet_data_out),
        .busy                  (busy),
        .frames_sent           (frames_sent),
        .error_out             (error_out),
        .Debug_LEDG            (Debug_LEDG)
    );

    always #20 CLOCK_25 = ~CLOCK_25;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLOCK_25);
        #1;
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    task automatic build_exp(input int md, input int plen, input logic [15:0] seq, input logic [15:0] cw);
        exp_w[0] = 16'hFFFF; exp_w[1] = 16'hFFFF; exp_w[2] = 16'hFFFF;
        exp_w[3] = 16'h0001; exp_w[4] = 16'h0203; exp_w[5] = 16'h0405;
        exp_w[6] = 16'h88B5; exp_w[7] = seq;
        for (int k = 0; k < plen; k++) begin
            case (md)
                0: exp_w[8+k] = 16'(k);
                1: exp_w[8+k] = cw;
                2: begin lfsr_m = lfsr_next(lfsr_m); exp_w[8+k] = lfsr_m; end
                default: exp_w[8+k] = seq;
            endcase
        end
    endtask

    task automatic cmp_frame(input string name, input int n);
        for (int i = 0; i < n; i++) check($sformatf("%s_w%0d", name, i), got_w[i], exp_w[i]);
    endtask

    task automatic start_run(input logic [1:0] md, input int pw, input int fc, input logic [15:0] cw, input logic stp);
        mode = md; payload_words = 16'(pw); frame_count = 16'(fc); const_word = cw;
        start_tx = 1'b1; stop_tx = stp;
        tick;
        start_tx = 1'b0; stop_tx = 1'b0;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!tx_req_out && n < 3000) begin tick; n++; end
        check("req_rise", tx_req_out, 1);
    endtask

    // Consume nwords with rdy every 'period' cycles, then complete 'cdelay' cycles later.
    task automatic do_frame(input int period, input int cdelay, input int nwords, input int stop_at);
        int cyc = 0;
        int got = 0;
        logic [15:0] prev = 16'h0;
        logic prev_cons = 1'b0;
        bit have_prev = 0;
        hold_errs = 0;
        while (got < nwords && cyc < 2000) begin
            if (have_prev && !prev_cons && (tx_packet_data_out !== prev)) hold_errs++;
            prev = tx_packet_data_out;
            have_prev = 1;
            prev_cons = ((cyc % period) == (period - 1)) && tx_req_out;
            if (prev_cons) begin got_w[got] = tx_packet_data_out; got++; end
            tx_packet_data_rdy_in = prev_cons;
            stop_tx = (cyc == stop_at);
            tick;
            cyc++;
        end
        tx_packet_data_rdy_in = 1'b0;
        stop_tx = 1'b0;
        check("frame_len", got, nwords);
        check("data_after_last", tx_packet_data_out, 16'h0000);
        check("req_held", tx_req_out, 1);
        repeat (cdelay - 1) tick;
        tx_complete_in = 1'b1;
        tick;
        tx_complete_in = 1'b0;
        check("req_drop", tx_req_out, 0);
    endtask

    initial begin
        int n;
        int rises;
        repeat (3) tick;
        check("rst_req", tx_req_out, 0);
        check("rst_data", tx_packet_data_out, 16'h0000);
        check("rst_busy", busy, 0);
        check("rst_sent", frames_sent, 0);
        check("rst_err", error_out, 0);
        check("rst_leds", Debug_LEDG, 9'h000);
        Reset = 1'b0;
        tick;

        // Basic frame, mode 0, 30 payload words.
        start_run(2'd0, 30, 1, 16'h0000, 1'b0);
        check("t1_first_word", tx_packet_data_out, 16'hFFFF);
        do_frame(1, 5, 38, -1);
        build_exp(0, 30, 16'h0000, 16'h0000);
        cmp_frame("t1", 38);
        tick;
        check("t1_sent", frames_sent, 1);
        check("t1_busy", busy, 0);
        check("t1_leds", Debug_LEDG, 9'h001);

        // Clamp to 22 payload words, three frames, sequence and gap.
        start_run(2'd0, 5, 3, 16'h0000, 1'b0);
        for (int f = 0; f < 3; f++) begin
            if (f > 0) begin
                wait_req(n);
                check("t2_gap_ge_1000", (n >= 1000), 1);
            end
            do_frame(1, 5, 30, -1);
            build_exp(0, 22, 16'(f), 16'h0000);
            cmp_frame($sformatf("t2f%0d", f), 30);
        end
        repeat (2) tick;
        check("t2_sent", frames_sent, 3);
        check("t2_busy", busy, 0);

        // Stalled consumer, constant payload.
        start_run(2'd1, 22, 1, 16'hBEEF, 1'b0);
        do_frame(3, 5, 30, -1);
        check("t3_hold", hold_errs, 0);
        build_exp(1, 22, 16'h0000, 16'hBEEF);
        cmp_frame("t3", 30);
        tick;
        check("t3_sent", frames_sent, 1);

        // LFSR payload across two frames.
        start_run(2'd2, 22, 2, 16'h0000, 1'b0);
        do_frame(1, 5, 30, -1);
        check("t4_first_lfsr", got_w[8], 16'h5670);
        check("t4_second_lfsr", got_w[9], 16'hAB38);
        build_exp(2, 22, 16'h0000, 16'h0000);
        cmp_frame("t4f0", 30);
        wait_req(n);
        do_frame(1, 5, 30, -1);
        build_exp(2, 22, 16'h0001, 16'h0000);
        cmp_frame("t4f1", 30);
        tick;
        check("t4_sent", frames_sent, 2);

        // Watchdog: no completion.
        start_run(2'd0, 22, 1, 16'h0000, 1'b0);
        n = 0;
        while (tx_req_out && n < 400) begin tick; n++; end
        check("t5_timeout_cycles", n, 200);
        check("t5_err", error_out, 1);
        check("t5_busy", busy, 0);
        check("t5_sent", frames_sent, 0);
        start_run(2'd0, 22, 1, 16'h0000, 1'b0);
        check("t5_err_cleared", error_out, 0);
        do_frame(1, 5, 30, -1);
        tick;
        check("t5_sent_after", frames_sent, 1);

        // Continuous run stopped during frame 2.
        start_run(2'd0, 22, 0, 16'h0000, 1'b0);
        do_frame(1, 5, 30, -1);
        wait_req(n);
        do_frame(1, 5, 30, 10);
        tick;
        check("t6_busy", busy, 0);
        check("t6_sent", frames_sent, 2);
        rises = 0;
        repeat (1100) begin tick; if (tx_req_out) rises++; end
        check("t6_no_frame3", rises, 0);

        // Reset in the middle of REQ.
        start_run(2'd0, 22, 1, 16'h0000, 1'b0);
        tx_packet_data_rdy_in = 1'b1;
        repeat (3) tick;
        tx_packet_data_rdy_in = 1'b0;
        tx_complete_in = 1'b1;
        Reset = 1'b1;
        tick;
        tx_complete_in = 1'b0;
        check("t7_req", tx_req_out, 0);
        check("t7_data", tx_packet_data_out, 16'h0000);
        check("t7_busy", busy, 0);
        check("t7_sent", frames_sent, 0);
        check("t7_leds", Debug_LEDG, 9'h000);
        Reset = 1'b0;
        tick;

        // Simultaneous start and stop: exactly one frame.
        start_run(2'd3, 22, 0, 16'h0000, 1'b1);
        do_frame(1, 5, 30, -1);
        build_exp(3, 22, 16'h0000, 16'h0000);
        cmp_frame("t8", 30);
        tick;
        check("t8_busy", busy, 0);
        check("t8_sent", frames_sent, 1);
        rises = 0;
        repeat (1100) begin tick; if (tx_req_out) rises++; end
        check("t8_single_frame", rises, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #(40 * 60000);
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
